s_mul_acc: RTL and testbench
============================

S_MUL_ACC -- requirements
Module: s_mul_acc

Interface
REQ-001 Parameter N, default 256: polynomial length, coefficients indexed 0..N-1, ring x^N+1.
REQ-002 Parameter W, default 13: coefficient width, arithmetic mod 2^W.
REQ-003 Parameter LAT, default 4: cycles from operand issue to valid product words at the multiplier outputs.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse: clear the accumulator and enter accumulation.
REQ-007 issue_vld  input  1  the operand pair for base index issue_idx enters the multiplier this cycle.
REQ-008 issue_idx  input  log2(N)  base coefficient index k of the issued pair; bit 0 is ignored, so k is always treated as even.
REQ-009 issue_last  input  1  qualifies issue_vld as the final issue of the job.
REQ-010 a0s0, a0s1_a1s0, a1s1  input  W each  product words from the multiplier, valid LAT cycles after the matching issue.
REQ-011 out_rdy  input  1  downstream accepts out_data.
REQ-012 out_vld  output  1  out_data and out_idx are valid.
REQ-013 out_data  output  W  accumulated coefficient.
REQ-014 out_idx  output  log2(N)  index of out_data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last coefficient is accepted.

Function
REQ-017 States: IDLE, ACC, DRAIN, OUT; reset state IDLE.
REQ-018 IDLE->ACC on start; the N-entry accumulator clears to 0 in the same edge.
REQ-019 start is ignored outside IDLE; issue_vld is ignored outside ACC.
REQ-020 A LAT-deep shift register carries {valid, k} from issue to product arrival; each delay line clears on start and on reset.
REQ-021 On a delayed-valid cycle: acc[k] += a0s0; acc[k+1] += a0s1_a1s0; acc[(k+2) mod N] += a1s1; all mod 2^W.
REQ-022 Negacyclic wrap: when k = N-2, a1s1 SHALL be subtracted from acc[0] instead of added.
REQ-023 The three target indices within one cycle are always distinct; back-to-back issues with overlapping indices SHALL accumulate correctly, with no lost update and no stall.
REQ-024 ACC->DRAIN on the issue_vld & issue_last cycle; DRAIN lasts exactly LAT cycles so that the final product is absorbed; DRAIN->OUT.
REQ-025 OUT streams acc[0]..acc[N-1] in order; out_idx starts at 0.
REQ-026 A beat transfers when out_vld & out_rdy; out_data and out_idx SHALL be held stable while out_vld & !out_rdy.
REQ-027 After the transfer of index N-1: done pulses for one cycle, out_vld drops, and the state returns to IDLE.
REQ-028 The accumulator SHALL retain its contents in IDLE until the next start.

Reset
REQ-029 While rst_n is low: state IDLE, out_vld=0, done=0, busy=0, out_idx=0, out_data=0, delay lines invalid, accumulator cleared to 0.
REQ-030 A reset asserted mid-job aborts the job immediately; the block SHALL then accept a new start one cycle after rst_n is released.

Verification
REQ-031 Single issue: start; issue k=4 with last; products 3/5/7 arrive LAT later -> stream shows acc[4]=3, acc[5]=5, acc[6]=7, all others 0; done pulses once.
REQ-032 Wrap: issue k=254 with a0s0=1, a0s1_a1s0=2, a1s1=1 -> acc[254]=1, acc[255]=2, acc[0]=8191.
REQ-033 Overlap: back-to-back issues k=0 then k=2, every product word = 1 -> acc[0..4] = 1,1,2,1,1.
REQ-034 Modulus: 16 issues at k=10 with a0s0=1024 -> acc[10]=0 (16384 mod 8192); random full jobs compared against a software negacyclic model.
REQ-035 Backpressure: hold out_rdy low for 5 cycles at out_idx=17 -> out_data and out_idx stay stable; no index is skipped or duplicated; exactly N beats transfer.
REQ-036 Reset in ACC with two issues in flight -> all outputs return to reset values; a new job after release shows no residue from the aborted job.

Source files
------------

// File: rtl/s_mul_acc.sv
// s_mul_acc: negacyclic accumulator for schoolbook products over Z_(2^W)[x]/(x^N+1).
// Absorbs three product words per issued operand pair, then streams the N coefficients out.
module s_mul_acc #(
    parameter int N   = 256,
    parameter int W   = 13,
    parameter int LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 issue_vld,
    input  logic [$clog2(N)-1:0] issue_idx,
    input  logic                 issue_last,
    input  logic [W-1:0]         a0s0,
    input  logic [W-1:0]         a0s1_a1s0,
    input  logic [W-1:0]         a1s1,
    input  logic                 out_rdy,
    output logic                 out_vld,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [IW-1:0] IDX_WRAP  = IW'(N - 2);
    localparam logic [IW-1:0] EVEN_MASK = {{(IW-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] DRAIN_END = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [LAT-1:0]  dl_vld_r;
    logic [IW-1:0]   dl_idx_r [LAT];
    logic [W-1:0]    acc_r [N];
    logic [CW-1:0]   drain_cnt_r;
    logic [IW-1:0]   out_idx_r;
    logic            done_r;

    logic            start_acc_s;
    logic            issue_acc_s;
    logic            xfer_s;
    logic            last_xfer_s;
    logic            prod_vld_s;
    logic            wrap_s;
    logic [IW-1:0]   k_s;
    logic [IW-1:0]   k1_s;
    logic [IW-1:0]   k2_s;

    // Handshake decode and target indices of the product arriving this cycle
    always_comb begin
        start_acc_s = (state_r == IDLE) && start;
        issue_acc_s = (state_r == ACC) && issue_vld;
        xfer_s      = (state_r == OUT) && out_rdy;
        last_xfer_s = xfer_s && (out_idx_r == IDX_LAST);
        prod_vld_s  = dl_vld_r[LAT-1];
        k_s         = dl_idx_r[LAT-1];
        k1_s        = k_s | IW'(1);
        wrap_s      = (k_s == IDX_WRAP);
        if (wrap_s) begin
            k2_s = {IW{1'b0}};
        end else begin
            k2_s = k_s + IW'(2);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (issue_vld && issue_last) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ACC;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_END) begin
                    state_s = OUT;
                end else begin
                    state_s = DRAIN;
                end
            end
            OUT: begin
                if (last_xfer_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode; out_data is gated so it reads zero whenever no beat is offered
    always_comb begin
        busy    = (state_r != IDLE);
        out_vld = (state_r == OUT);
        out_idx = out_idx_r;
        done    = done_r;
        if (state_r == OUT) begin
            out_data = acc_r[out_idx_r];
        end else begin
            out_data = {W{1'b0}};
        end
    end

    // Counts the LAT drain cycles that let the final product land
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r <= {CW{1'b0}};
        end else if (state_r == DRAIN) begin
            drain_cnt_r <= drain_cnt_r + CW'(1);
        end else begin
            drain_cnt_r <= {CW{1'b0}};
        end
    end

    // Issue-to-product delay line carrying {valid, even base index}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                dl_idx_r[i] <= {IW{1'b0}};
            end
        end else if (start_acc_s) begin
            dl_vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                dl_idx_r[i] <= {IW{1'b0}};
            end
        end else begin
            dl_vld_r[0] <= issue_acc_s;
            dl_idx_r[0] <= issue_idx & EVEN_MASK;
            for (int i = 1; i < LAT; i++) begin
                dl_vld_r[i] <= dl_vld_r[i-1];
                dl_idx_r[i] <= dl_idx_r[i-1];
            end
        end
    end

    // Accumulator: k, k+1, k+2 are always distinct, so three independent writes per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                acc_r[i] <= {W{1'b0}};
            end
        end else if (start_acc_s) begin
            for (int i = 0; i < N; i++) begin
                acc_r[i] <= {W{1'b0}};
            end
        end else if (prod_vld_s) begin
            acc_r[k_s]  <= acc_r[k_s] + a0s0;
            acc_r[k1_s] <= acc_r[k1_s] + a0s1_a1s0;
            if (wrap_s) begin
                acc_r[k2_s] <= acc_r[k2_s] - a1s1;
            end else begin
                acc_r[k2_s] <= acc_r[k2_s] + a1s1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                acc_r[i] <= acc_r[i];
            end
        end
    end

    // Output index and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_r <= {IW{1'b0}};
            done_r    <= 1'b0;
        end else if (last_xfer_s) begin
            out_idx_r <= {IW{1'b0}};
            done_r    <= 1'b1;
        end else if (xfer_s) begin
            out_idx_r <= out_idx_r + IW'(1);
            done_r    <= 1'b0;
        end else begin
            out_idx_r <= out_idx_r;
            done_r    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s_mul_acc.sv
// tb_s_mul_acc: table vectors, hand sequences and random jobs for s_mul_acc,
// checked against a negacyclic polynomial model computed with plain arithmetic.
module tb_s_mul_acc;

    localparam int N   = 256;
    localparam int W   = 13;
    localparam int LAT = 4;
    localparam int IW  = 8;
    localparam int MOD = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          issue_vld = 1'b0;
    logic [IW-1:0] issue_idx = '0;
    logic          issue_last = 1'b0;
    logic [W-1:0]  a0s0 = '0;
    logic [W-1:0]  a0s1_a1s0 = '0;
    logic [W-1:0]  a1s1 = '0;
    logic          out_rdy = 1'b0;
    logic          out_vld;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          busy;
    logic          done;

    s_mul_acc #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .issue_vld(issue_vld),
        .issue_idx(issue_idx), .issue_last(issue_last), .a0s0(a0s0),
        .a0s1_a1s0(a0s1_a1s0), .a1s1(a1s1), .out_rdy(out_rdy),
        .out_vld(out_vld), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {bit vld; int k; int p0; int p1; int p2;} iss_t;
    typedef struct {int k; int p0; int p1; int p2;
                    int i0; int v0; int i1; int v1; int i2; int v2;} vec_t;

    iss_t job[$];
    vec_t vt[5];
    int   model[N];
    int   got[N];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Adds v at coefficient i of the product; indices past N-1 wrap with sign flip (x^N = -1)
    function automatic void add_coef(input int i, input int v);
        if (i >= N) model[i-N] = (model[i-N] - v + MOD) % MOD;
        else        model[i]   = (model[i] + v) % MOD;
    endfunction

    function automatic void build_model();
        int kb;
        for (int i = 0; i < N; i++) model[i] = 0;
        foreach (job[j]) begin
            if (job[j].vld) begin
                kb = job[j].k - (job[j].k % 2);
                add_coef(kb,     job[j].p0);
                add_coef(kb + 1, job[j].p1);
                add_coef(kb + 2, job[j].p2);
            end
        end
    endfunction

    task automatic junk_products();
        a0s0      = W'($urandom);
        a0s1_a1s0 = W'($urandom);
        a1s1      = W'($urandom);
    endtask

    // Called positioned at a negedge; pulses start here, runs the job and collects the stream
    task automatic run_job(input int bp_mode, input string tag);
        int beats = 0, cycles = 0, order_err = 0, data_err = 0, hold_err = 0;
        int stall17 = 0, stall_left = 0, early_done = 0, first_bad = -1;
        bit stalled_once = 1'b0, prev_hold = 1'b0;
        logic [W-1:0]  prev_data = '0;
        logic [IW-1:0] prev_idx = '0;
        build_model();
        for (int i = 0; i < N; i++) got[i] = -1;
        start = 1'b1;
        for (int t = 0; t < job.size() + LAT; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == 0) chk({tag, "_busy"}, int'(busy), 1);
            if (t < job.size()) begin
                issue_vld  = job[t].vld;
                issue_idx  = IW'(job[t].k);
                issue_last = (t == job.size() - 1);
            end else begin
                issue_vld  = 1'($urandom_range(0, 1));
                issue_idx  = IW'($urandom);
                issue_last = 1'($urandom_range(0, 1));
            end
            if (t >= LAT && job[t-LAT].vld) begin
                a0s0      = W'(job[t-LAT].p0);
                a0s1_a1s0 = W'(job[t-LAT].p1);
                a1s1      = W'(job[t-LAT].p2);
            end else begin
                junk_products();
            end
        end
        while (beats < N && cycles < N * 4 + 100) begin
            @(negedge clk);
            cycles++;
            start      = ($urandom_range(0, 7) == 0);
            issue_vld  = 1'($urandom_range(0, 1));
            issue_last = 1'($urandom_range(0, 1));
            junk_products();
            if (done) early_done++;
            if (prev_hold && (!out_vld || out_data != prev_data || out_idx != prev_idx)) hold_err++;
            if (bp_mode == 2 && out_vld && out_idx == IW'(17) && !stalled_once) begin
                stalled_once = 1'b1;
                stall_left   = 5;
            end
            if (stall_left > 0) begin
                out_rdy = 1'b0;
                stall_left--;
            end else if (bp_mode == 1) begin
                out_rdy = ($urandom_range(0, 2) != 0);
            end else begin
                out_rdy = 1'b1;
            end
            if (out_vld && !out_rdy && out_idx == IW'(17)) stall17++;
            prev_hold = out_vld && !out_rdy;
            prev_data = out_data;
            prev_idx  = out_idx;
            if (out_vld && out_rdy) begin
                if (int'(out_idx) != beats) order_err++;
                got[out_idx] = int'(out_data);
                beats++;
            end
        end
        @(negedge clk);
        start = 1'b0; issue_vld = 1'b0; issue_last = 1'b0; out_rdy = 1'b0;
        chk({tag, "_done_pulse"}, int'(done), 1);
        chk({tag, "_vld_drop"}, int'(out_vld), 0);
        chk({tag, "_idle"}, int'(busy), 0);
        @(negedge clk);
        chk({tag, "_done_single"}, int'(done), 0);
        for (int i = 0; i < N; i++) begin
            if (got[i] != model[i]) begin
                if (first_bad < 0) first_bad = i;
                data_err++;
            end
        end
        if (first_bad >= 0)
            $display("  %s first bad coefficient %0d: got %0d model %0d", tag, first_bad,
                     got[first_bad], model[first_bad]);
        chk({tag, "_beats"}, beats, N);
        chk({tag, "_order"}, order_err, 0);
        chk({tag, "_stream_data"}, data_err, 0);
        chk({tag, "_hold"}, hold_err, 0);
        chk({tag, "_no_early_done"}, early_done, 0);
        if (bp_mode == 2) chk({tag, "_stall17"}, stall17, 5);
    endtask

    task automatic random_job(input int len);
        job.delete();
        for (int i = 0; i < len; i++)
            job.push_back('{(i == len - 1) ? 1'b1 : 1'($urandom_range(0, 3) != 0),
                            int'($urandom_range(0, N - 1)), int'($urandom_range(0, MOD - 1)),
                            int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1))});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ovl[5];
        exp_ovl = '{1, 1, 2, 1, 1};
        vt[0] = '{4,   3,    5,    7,    4,   3,    5,   5,    6,   7};
        vt[1] = '{254, 1,    2,    1,    254, 1,    255, 2,    0,   8191};
        vt[2] = '{255, 8191, 8191, 2,    254, 8191, 255, 8191, 0,   8190};
        vt[3] = '{0,   4096, 1,    8191, 0,   4096, 1,   1,    2,   8191};
        vt[4] = '{128, 13,   26,   39,   128, 13,   129, 26,   130, 39};

        repeat (3) @(negedge clk);
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            job.delete();
            job.push_back('{1'b1, vt[v].k, vt[v].p0, vt[v].p1, vt[v].p2});
            @(negedge clk);
            run_job(0, "vec");
            chk("vec_i0", got[vt[v].i0], vt[v].v0);
            chk("vec_i1", got[vt[v].i1], vt[v].v1);
            chk("vec_i2", got[vt[v].i2], vt[v].v2);
        end

        job.delete();
        job.push_back('{1'b1, 0, 1, 1, 1});
        job.push_back('{1'b1, 2, 1, 1, 1});
        @(negedge clk);
        run_job(1, "ovl");
        for (int i = 0; i < 5; i++) chk("ovl_coef", got[i], exp_ovl[i]);

        job.delete();
        for (int i = 0; i < 16; i++) job.push_back('{1'b1, 10, 1024, 0, 0});
        @(negedge clk);
        run_job(0, "mod");
        chk("mod_acc10", got[10], 0);

        random_job(12);
        @(negedge clk);
        run_job(2, "bp");

        for (int r = 0; r < 4; r++) begin
            random_job(int'($urandom_range(1, 48)));
            @(negedge clk);
            run_job(1, "rand");
        end

        // Abort a job with two issues still in the delay line
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; issue_vld = 1'b1; issue_idx = IW'(8); issue_last = 1'b0;
        a0s0 = W'(100); a0s1_a1s0 = W'(200); a1s1 = W'(300);
        @(negedge clk);
        issue_idx = IW'(30);
        @(negedge clk);
        issue_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_out_vld", int'(out_vld), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_idx", int'(out_idx), 0);
        chk("abort_out_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        job.delete();
        job.push_back('{1'b1, 20, 1, 1, 1});
        run_job(0, "post_rst");
        chk("post_rst_acc8", got[8], 0);
        chk("post_rst_acc30", got[30], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
